// File: rtl/reg_hazard_ctrl.sv
// Hazard and write-back sequencer for the 8 x 16-bit register file.
// Tracks in-flight destinations through EX/MEM/WB, selects operand forwarding,
// stalls decode on load-use hazards and drives the register file write port.
module reg_hazard_ctrl #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [2:0]       id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [NREG-1:0]  busy_mask,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  // WB no longer needs the load flag: its data is always ready.
  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       reg_write;
  } wb_slot_t;

  slot_t            r_ex;
  slot_t            r_mem;
  wb_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  logic             w_load_hit1;
  logic             w_load_hit2;

  function automatic logic hits(input logic valid, input logic we, input logic [2:0] dst,
                                input logic [2:0] r);
    return valid & we & (dst == r);
  endfunction

  // Youngest producer wins; loads in EX/MEM cannot forward (handled by stall).
  function automatic logic [1:0] pick(input logic use_src, input logic [2:0] src,
                                      input slot_t ex, input slot_t mem, input wb_slot_t wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (!use_src) begin
      sel = 2'd0;
    end else if (hits(ex.valid, ex.reg_write, ex.dst, src) && !ex.mem_read) begin
      sel = 2'd1;
    end else if (hits(mem.valid, mem.reg_write, mem.dst, src) && !mem.mem_read) begin
      sel = 2'd2;
    end else if (hits(wb.valid, wb.reg_write, wb.dst, src)) begin
      sel = 2'd3;
    end
    return sel;
  endfunction

  // Load-use detection against loads still in EX or MEM; flush overrides.
  always_comb begin
    w_load_hit1 = id_use_src1 &
                  ((hits(r_ex.valid, r_ex.reg_write, r_ex.dst, id_src1) & r_ex.mem_read) |
                   (hits(r_mem.valid, r_mem.reg_write, r_mem.dst, id_src1) & r_mem.mem_read));
    w_load_hit2 = id_use_src2 &
                  ((hits(r_ex.valid, r_ex.reg_write, r_ex.dst, id_src2) & r_ex.mem_read) |
                   (hits(r_mem.valid, r_mem.reg_write, r_mem.dst, id_src2) & r_mem.mem_read));
    w_stall     = id_valid & ~flush & (w_load_hit1 | w_load_hit2);
  end

  // Per-source forwarding selects.
  always_comb begin
    fwd_sel1 = pick(id_use_src1, id_src1, r_ex, r_mem, r_wb);
    fwd_sel2 = pick(id_use_src2, id_src2, r_ex, r_mem, r_wb);
  end

  // Registers that some in-flight slot will write.
  always_comb begin
    busy_mask = '0;
    if (r_ex.valid && r_ex.reg_write)   busy_mask[r_ex.dst]  = 1'b1;
    if (r_mem.valid && r_mem.reg_write) busy_mask[r_mem.dst] = 1'b1;
    if (r_wb.valid && r_wb.reg_write)   busy_mask[r_wb.dst]  = 1'b1;
  end

  // Slot advance: EX takes a bubble on stall; flush squashes decode, EX and MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex.valid      <= id_valid & ~w_stall & ~flush;
      r_ex.dst        <= id_dst;
      r_ex.reg_write  <= id_reg_write;
      r_ex.mem_read   <= id_mem_read;
      r_mem.valid     <= r_ex.valid & ~flush;
      r_mem.dst       <= r_ex.dst;
      r_mem.reg_write <= r_ex.reg_write;
      r_mem.mem_read  <= r_ex.mem_read;
      r_wb.valid      <= r_mem.valid & ~flush;
      r_wb.dst        <= r_mem.dst;
      r_wb.reg_write  <= r_mem.reg_write;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall       = w_stall;
  assign rf_we       = r_wb.valid & r_wb.reg_write;
  assign rf_waddr    = r_wb.dst;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Directed self-checking bench for reg_hazard_ctrl (stall counter built 4 bits wide).
module tb_reg_hazard_ctrl;

  localparam int unsigned NREG  = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [2:0]       id_src1;
  logic [2:0]       id_src2;
  logic             id_use_src1;
  logic             id_use_src2;
  logic [2:0]       id_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic             rf_we;
  logic [2:0]       rf_waddr;
  logic [NREG-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_count;

  int n_cmp;
  int n_err;

  reg_hazard_ctrl #(
    .NREG  (NREG),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .busy_mask    (busy_mask),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [2:0] dst, input logic rw, input logic mr,
                       input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                       input logic u2);
    id_valid     = v;
    id_dst       = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_src1      = s1;
    id_use_src1  = u1;
    id_src2      = s2;
    id_use_src2  = u2;
  endtask

  task automatic idle();
    issue(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // Advance past the next rising edge; inputs are then driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point: the falling edge, mid-cycle.
  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  function automatic int all_outs();
    return int'({stall, fwd_sel1, fwd_sel2, rf_we, rf_waddr, busy_mask, stall_count});
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    flush = 1'b0;
    idle();

    at_neg();
    chk("reset_outs", all_outs(), 0);
    cyc();
    reset = 1'b0;

    // Idle after reset: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("idle_outs", all_outs(), 0);
      cyc();
    end

    // Back-to-back ALU RAW on r3.
    issue(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    at_neg();
    chk("raw_busy0", int'(busy_mask), 0);
    cyc();
    issue(1'b1, 3'd1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    at_neg();
    chk("raw_sel1_ex", int'(fwd_sel1), 1);
    chk("raw_stall", int'(stall), 0);
    chk("raw_busy_r3", int'(busy_mask), 8'h08);
    cyc();
    issue(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1);
    at_neg();
    chk("raw_sel2_mem", int'(fwd_sel2), 2);
    chk("raw_sel1_unused", int'(fwd_sel1), 0);
    cyc();
    issue(1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0);
    at_neg();
    chk("raw_sel1_wb", int'(fwd_sel1), 3);
    chk("raw_rf_we", int'(rf_we), 1);
    chk("raw_rf_waddr", int'(rf_waddr), 3);
    cyc();
    idle();
    at_neg();
    chk("raw_sub_waddr", int'(rf_waddr), 1);
    chk("raw_sub_we", int'(rf_we), 1);
    drain();

    // Load-use on r5: two stall cycles, then WB forward.
    issue(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd6, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0);
    at_neg();
    chk("lu_stall_ex", int'(stall), 1);
    chk("lu_busy_ex", int'(busy_mask), 8'h20);
    cyc();
    at_neg();
    chk("lu_stall_mem", int'(stall), 1);
    chk("lu_busy_mem", int'(busy_mask), 8'h20);
    cyc();
    at_neg();
    chk("lu_stall_wb", int'(stall), 0);
    chk("lu_sel1_wb", int'(fwd_sel1), 3);
    chk("lu_count", int'(stall_count), 2);
    cyc();
    idle();
    at_neg();
    chk("lu_add_in_ex", int'(busy_mask), 8'h40);
    drain();

    // Youngest producer wins.
    issue(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd7, 1'b0, 1'b0, 3'd2, 1'b1, 3'd2, 1'b1);
    at_neg();
    chk("yw_sel1", int'(fwd_sel1), 1);
    chk("yw_sel2", int'(fwd_sel2), 1);
    drain();

    // Flush: r1 in WB completes; r4 (MEM) and load r6 (EX) are squashed.
    issue(1'b1, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd7, 1'b1, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0);
    flush = 1'b1;
    at_neg();
    chk("fl_stall_forced0", int'(stall), 0);
    chk("fl_busy", int'(busy_mask), 8'h52);
    chk("fl_wb_we", int'(rf_we), 1);
    chk("fl_wb_addr", int'(rf_waddr), 1);
    cyc();
    flush = 1'b0;
    idle();
    at_neg();
    chk("fl_rf_we_after", int'(rf_we), 0);
    chk("fl_busy_after", int'(busy_mask), 0);
    chk("fl_count_held", int'(stall_count), 2);
    cyc();
    at_neg();
    chk("fl_rf_we_after2", int'(rf_we), 0);
    drain();

    // Ten load-use pairs give 20 more stall cycles; the counter saturates.
    for (int k = 0; k < 10; k++) begin
      issue(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      at_neg();
      chk("sat_ld_stall", int'(stall), 0);
      cyc();
      issue(1'b1, 3'd6, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0);
      at_neg();
      chk("sat_stall_a", int'(stall), 1);
      cyc();
      at_neg();
      chk("sat_stall_b", int'(stall), 1);
      cyc();
      at_neg();
      chk("sat_stall_c", int'(stall), 0);
      cyc();
    end
    idle();
    at_neg();
    chk("sat_count", int'(stall_count), 15);
    drain();

    // Asynchronous reset in the middle of a stall.
    issue(1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
    cyc();
    issue(1'b1, 3'd6, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0);
    at_neg();
    chk("ar_stall_pre", int'(stall), 1);
    chk("ar_count_pre", int'(stall_count), 15);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_stall_async", int'(stall), 0);
    chk("ar_count_async", int'(stall_count), 0);
    chk("ar_busy_async", int'(busy_mask), 0);
    cyc();
    reset = 1'b0;
    idle();
    at_neg();
    chk("ar_outs_after", all_outs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_hazard_ctrl.md
# reg_hazard_ctrl

Hazard and write-back sequencer for the 8 x 16-bit register file. Tracks the destination register of every in-flight instruction through the three post-decode stages (EX, MEM, WB), decides per decode slot whether each source operand reads the register file or takes a forwarded value, and stalls decode on load-use hazards. It drives the register file write enable and write address from the WB slot, replacing the ad-hoc address delay line.

## Interface

Parameters:
- NREG, 8, number of architectural registers (address width = 3)
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_src1  in  3  first source register
- id_src2  in  3  second source register
- id_use_src1  in  1  instruction reads id_src1
- id_use_src2  in  1  instruction reads id_src2
- id_dst  in  3  destination register
- id_reg_write  in  1  instruction writes id_dst
- id_mem_read  in  1  instruction is a load; result available only at WB
- flush  in  1  squash decode, EX and MEM slots (branch taken)
- stall  out  1  hold fetch/decode this cycle
- fwd_sel1  out  2  source 1 select: 0 regfile, 1 EX result, 2 MEM result, 3 WB data
- fwd_sel2  out  2  source 2 select, same encoding
- rf_we  out  1  register file write enable (WB slot)
- rf_waddr  out  3  register file write address (WB slot)
- busy_mask  out  NREG  bit r set when any valid EX/MEM/WB slot will write r
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation

- Three slot registers EX, MEM, WB; each holds valid, dst[2:0], reg_write, mem_read. A slot "writes r" when valid & reg_write & dst == r.
- Advance each rising edge: WB <- MEM, MEM <- EX, EX <- decode slot (valid = id_valid & ~stall & ~flush). All slots advance even during stall; only EX receives a bubble.
- Load-use stall (combinational): stall = id_valid & ~flush & ((id_use_src1 & EX writes id_src1) | (id_use_src2 & EX writes id_src2)) & EX.mem_read. A load in MEM matching a source also stalls (data not ready until WB).
- Forwarding (combinational, per source, youngest wins): EX writes src and EX not a load -> 1; else MEM writes src and MEM not a load -> 2; else WB writes src -> 3; else 0. If the source is unused, sel = 0. Register 0 is not special.
- rf_we = WB.valid & WB.reg_write; rf_waddr = WB.dst.
- busy_mask = OR over EX, MEM and WB of the one-hot of dst where the slot writes.
- stall_count increments by 1 each cycle stall is high; holds at 2^CNT_W-1.
- flush: at the next edge EX and MEM become invalid; WB is loaded from the old MEM, which is squashed, so it becomes invalid too. Instructions already in WB at the flush edge complete. When flush is high, stall is forced low.

## Timing

- Reset (asynchronous): all slot valids 0, stall 0, fwd_sel1/2 0, rf_we 0, rf_waddr 0, busy_mask 0, stall_count 0.
- Write-back latency: an instruction accepted in decode at edge N is in EX after N, MEM after N+1, and WB after N+2; rf_we is asserted during the cycle after edge N+2.
- Load-use: at most 2 stall cycles when a dependent instruction immediately follows a load (EX match, then MEM match), then it issues with sel = 3.
- Register file same-cycle write/read: WB match forwards (sel 3), so decode never depends on write-before-read ordering.
- Simultaneous flush and stall condition: flush wins and no stall is counted.
- Reset mid-stall: stall drops immediately (asynchronous) and the counter clears.

## Test plan

- Reset then idle: after reset is released, all outputs stay 0 for 10 cycles with id_valid=0.
- Back-to-back ALU RAW: ADD r3 (dst=3), then SUB using src1=3 on the next cycle -> fwd_sel1=1, stall=0; a third instruction using src2=3 -> fwd_sel2=2; a fourth -> sel=3; rf_we=1 with rf_waddr=3 exactly 3 cycles after ADD enters decode.
- Load-use: LDD r5, then ADD src1=5 -> stall=1 for 2 cycles, stall_count=2, then fwd_sel1=3 and the ADD enters EX; busy_mask bit 5 is set while the load is in flight.
- Youngest-wins: writes to r2 in consecutive cycles, followed by a reader of r2 -> fwd_sel=1, not 2 or 3.
- Flush: two writers of r4 and r6 in EX/MEM, assert flush for 1 cycle -> rf_we stays 0 for both; busy_mask clears once the in-flight WB retires; stall=0 during flush even if a load-use condition is present.
- Saturation and async reset: with CNT_W=4, hold a load-use condition for 20 cycles -> stall_count=15; assert reset mid-cycle -> stall_count=0 and stall=0 before the next edge.
